// File: rtl/alu_exec_unit.sv
// ALU execute stage: decodes ALUOp/funct and registers a single-cycle result
// one cycle after issue. MUL runs as an iterative shift-add over WIDTH cycles
// with busy_o held high so the hazard unit can stall the pipeline.
module alu_exec_unit #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       ALUOp_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             illegal_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_SLT,
    OP_MUL,
    OP_ILL
  } op_t;

  state_t           state_q;
  op_t              op;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    count_q;
  logic             busy_q;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             zero_q;
  logic             illegal_q;

  // Only funct[3:0] selects the operation; the upper bits are ignored.
  logic unused_funct_hi;
  assign unused_funct_hi = ^funct_i[5:4];

  // Decode ALUOp/funct into an internal operation.
  always_comb begin
    op = OP_ILL;
    case (ALUOp_i)
      2'b00, 2'b10: op = OP_ADD;
      2'b01:        op = OP_SUB;
      default: begin
        case (funct_i[3:0])
          4'b0000: op = OP_ADD;
          4'b0010: op = OP_SUB;
          4'b0100: op = OP_AND;
          4'b0101: op = OP_OR;
          4'b1010: op = OP_SLT;
          4'b1000: op = MUL_EN ? OP_MUL : OP_ILL;
          default: op = OP_ILL;
        endcase
      end
    endcase
  end

  // Single-cycle datapath; illegal and MUL produce zero here.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD: alu_res = data1_i + data2_i;
      OP_SUB: alu_res = data1_i - data2_i;
      OP_AND: alu_res = data1_i & data2_i;
      OP_OR:  alu_res = data1_i | data2_i;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
      default: alu_res = '0;
    endcase
  end

  // One shift-add multiply step, multiplier consumed LSB first.
  always_comb begin
    acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mcand_d  = mcand_q << 1;
    mplier_d = mplier_q >> 1;
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (op == OP_MUL) begin
              acc_q    <= '0;
              mcand_q  <= data1_i;
              mplier_q <= data2_i;
              count_q  <= CW'(WIDTH);
              busy_q   <= 1'b1;
              state_q  <= S_MUL;
            end else begin
              valid_q   <= 1'b1;
              data_q    <= alu_res;
              zero_q    <= (op == OP_ILL) || (alu_res == '0);
              illegal_q <= (op == OP_ILL);
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          count_q  <= count_q - 1'b1;
          // Final step: publish acc_d directly so the product lands with valid_o.
          if (count_q == CW'(1)) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            valid_q   <= 1'b1;
            data_q    <= acc_d;
            zero_q    <= (acc_d == '0);
            illegal_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign zero_o    = zero_q;
  assign illegal_o = illegal_q;

endmodule
